// File: rtl/io_mem_ctrl_if.sv
// Core-side data-memory bus of io_mem_ctrl: word address, write data/enable, and read data.
interface io_mem_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic              wea;
   logic [DATA_W-1:0] data_out;

   modport master (output address, output data_in, output wea, input data_out);
   modport slave  (input address, input data_in, input wea, output data_out);
endinterface

// File: rtl/io_mem_ctrl.sv
// Single-port RAM with a 16-word memory-mapped IO window (input capture, output registers, status).
// Optional macro IO_SYNC_EN: synchronise in_valid and capture on its rising edge only.
module io_mem_ctrl #(
   parameter int                DATA_W  = 16,
   parameter int                ADDR_W  = 16,
   parameter int                MEM_AW  = 10,
   parameter int                N_IN    = 2,
   parameter int                N_OUT   = 2,
   parameter logic [ADDR_W-1:0] IO_BASE = 16'h7FF0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   io_mem_ctrl_if.slave            bus,
   input  logic [N_IN*DATA_W-1:0]  in_data,
   input  logic [N_IN-1:0]         in_valid,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic [N_OUT-1:0]        out_strobe
);

   logic [DATA_W-1:0] ram [0:(2**MEM_AW)-1];

   logic              io_hit;
   logic [3:0]        off;
   logic [MEM_AW-1:0] mem_addr;
   logic [N_IN-1:0]   cap;
   logic [DATA_W-1:0] status;

   logic [N_IN*DATA_W-1:0]  in_reg_q, in_reg_d;
   logic [N_IN-1:0]         in_new_q, in_new_d;
   logic [N_OUT*DATA_W-1:0] out_reg_q, out_reg_d;
   logic [N_OUT-1:0]        out_strobe_q, out_strobe_d;
   logic [DATA_W-1:0]       mem_q;
   logic [DATA_W-1:0]       io_q, io_d;
   logic                    sel_q;

   assign io_hit   = (bus.address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
   assign off      = bus.address[3:0];
   assign mem_addr = bus.address[MEM_AW-1:0];
   assign status   = DATA_W'(in_new_q);

`ifdef IO_SYNC_EN
   logic [N_IN-1:0] sync1_q, sync2_q, sync3_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= in_valid;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // one capture per synchronised rising edge, so a held strobe captures once
   assign cap = sync2_q & ~sync3_q;
`else
   assign cap = in_valid;
`endif

   always_comb begin
      in_reg_d     = in_reg_q;
      in_new_d     = in_new_q;
      out_reg_d    = out_reg_q;
      out_strobe_d = '0;
      io_d         = '0;

      for (int i = 0; i < N_IN; i++) begin
         if (io_hit && !bus.wea && off == 4'(i))
            in_new_d[i] = 1'b0;
         if (io_hit && bus.wea && off == 4'hF && bus.data_in[i])
            in_new_d[i] = 1'b0;
         // a coincident capture beats any clear; the read mux still sees the old word
         if (cap[i]) begin
            in_new_d[i]                   = 1'b1;
            in_reg_d[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
         end
         if (off == 4'(i))
            io_d = in_reg_q[i*DATA_W +: DATA_W];
      end

      for (int j = 0; j < N_OUT; j++) begin
         if (off == 4'(8 + j)) begin
            io_d = out_reg_q[j*DATA_W +: DATA_W];
            if (io_hit && bus.wea) begin
               out_reg_d[j*DATA_W +: DATA_W] = bus.data_in;
               out_strobe_d[j]               = 1'b1;
            end
         end
      end

      if (off == 4'hF)
         io_d = status;
   end

   always_ff @(posedge clk) begin
      if (rst_n && bus.wea && !io_hit)
         ram[mem_addr] <= bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_reg_q     <= '0;
         in_new_q     <= '0;
         out_reg_q    <= '0;
         out_strobe_q <= '0;
         mem_q        <= '0;
         io_q         <= '0;
         sel_q        <= 1'b0;
      end else begin
         in_reg_q     <= in_reg_d;
         in_new_q     <= in_new_d;
         out_reg_q    <= out_reg_d;
         out_strobe_q <= out_strobe_d;
         mem_q        <= ram[mem_addr];
         io_q         <= io_d;
         sel_q        <= io_hit;
      end
   end

   assign bus.data_out = sel_q ? io_q : mem_q;
   assign out_data     = out_reg_q;
   assign out_strobe   = out_strobe_q;

endmodule

// File: tb/tb_io_mem_ctrl.sv
// Directed bench for io_mem_ctrl: RAM path, IO window, input capture, output strobes, reset.
module tb_io_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic [1:0]  in_valid;
   logic [31:0] out_data;
   logic [1:0]  out_strobe;

   int pass_cnt;
   int total_cnt;

   io_mem_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   io_mem_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_strobe (out_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
      bus.address = a;
      bus.data_in = d;
      bus.wea     = 1'b1;
      tick();
      bus.wea     = 1'b0;
      bus.address = 16'h0000;
   endtask

   task automatic bus_rd(input logic [15:0] a);
      bus.address = a;
      bus.wea     = 1'b0;
      tick();
      bus.address = 16'h0000;
   endtask

   task automatic wait_capture;
`ifdef IO_SYNC_EN
      repeat (2) tick();
`endif
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) tick();
      total_cnt++;
      if (bus.data_out !== 16'h0000) $display("FAIL rst_data_out: got %h expected 0000", bus.data_out);
      else pass_cnt++;
      total_cnt++;
      if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h expected 00000000", out_data);
      else pass_cnt++;
      total_cnt++;
      if (out_strobe !== 2'b00) $display("FAIL rst_out_strobe: got %b expected 00", out_strobe);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ram;
      bus_wr(16'h0005, 16'h1234);
      bus_rd(16'h0005);
      total_cnt++;
      if (bus.data_out !== 16'h1234) $display("FAIL ram_rd: got %h expected 1234", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h0405);
      total_cnt++;
      if (bus.data_out !== 16'h1234) $display("FAIL ram_alias: got %h expected 1234", bus.data_out);
      else pass_cnt++;
      bus_wr(16'h03F8, 16'h5A5A);
      bus_wr(16'h7FF8, 16'hDEAD);
      total_cnt++;
      if (out_data[15:0] !== 16'hDEAD) $display("FAIL io_wr_ch0: got %h expected dead", out_data[15:0]);
      else pass_cnt++;
      bus_rd(16'h03F8);
      total_cnt++;
      if (bus.data_out !== 16'h5A5A) $display("FAIL io_wr_no_ram: got %h expected 5a5a", bus.data_out);
      else pass_cnt++;
      bus_wr(16'h0005, 16'h7777);
      total_cnt++;
      if (bus.data_out !== 16'h1234) $display("FAIL ram_rbw: got %h expected 1234", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h0005);
      total_cnt++;
      if (bus.data_out !== 16'h7777) $display("FAIL ram_rd2: got %h expected 7777", bus.data_out);
      else pass_cnt++;
   endtask

   task automatic test_input_capture;
      bus.address = 16'h0000;
      in_data     = {16'h0000, 16'hBEEF};
      in_valid    = 2'b01;
      tick();
      in_valid    = 2'b00;
      wait_capture();
      bus_rd(16'h7FFF);
      total_cnt++;
      if (bus.data_out !== 16'h0001) $display("FAIL cap_status: got %h expected 0001", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h7FF0);
      total_cnt++;
      if (bus.data_out !== 16'hBEEF) $display("FAIL cap_ch0: got %h expected beef", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h7FFF);
      total_cnt++;
      if (bus.data_out !== 16'h0000) $display("FAIL cap_status_clr: got %h expected 0000", bus.data_out);
      else pass_cnt++;
   endtask

   task automatic test_read_collision;
      in_data  = {16'h5555, 16'h0000};
      in_valid = 2'b10;
      tick();
      in_valid = 2'b00;
      in_data  = {16'hAAAA, 16'h0000};
      in_valid = 2'b10;
      bus_rd(16'h7FF1);
      in_valid = 2'b00;
      total_cnt++;
      if (bus.data_out !== 16'h5555) $display("FAIL coll_old: got %h expected 5555", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h7FFF);
      total_cnt++;
      if (bus.data_out !== 16'h0002) $display("FAIL coll_status: got %h expected 0002", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h7FF1);
      total_cnt++;
      if (bus.data_out !== 16'hAAAA) $display("FAIL coll_new: got %h expected aaaa", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h7FFF);
      total_cnt++;
      if (bus.data_out !== 16'h0000) $display("FAIL coll_status_clr: got %h expected 0000", bus.data_out);
      else pass_cnt++;
   endtask

   task automatic test_output;
      bus_wr(16'h7FF9, 16'h00FF);
      total_cnt++;
      if (out_data[31:16] !== 16'h00FF) $display("FAIL out_ch1: got %h expected 00ff", out_data[31:16]);
      else pass_cnt++;
      total_cnt++;
      if (out_strobe !== 2'b10) $display("FAIL out_strobe_ch1: got %b expected 10", out_strobe);
      else pass_cnt++;
      total_cnt++;
      if (out_data[15:0] !== 16'hDEAD) $display("FAIL out_ch0_keep: got %h expected dead", out_data[15:0]);
      else pass_cnt++;
      bus_rd(16'h7FF9);
      total_cnt++;
      if (bus.data_out !== 16'h00FF) $display("FAIL out_rd_ch1: got %h expected 00ff", bus.data_out);
      else pass_cnt++;
      total_cnt++;
      if (out_strobe !== 2'b00) $display("FAIL out_strobe_end: got %b expected 00", out_strobe);
      else pass_cnt++;
      bus_wr(16'h7FF8, 16'h0101);
      total_cnt++;
      if (out_strobe !== 2'b01) $display("FAIL b2b_strobe1: got %b expected 01", out_strobe);
      else pass_cnt++;
      bus_wr(16'h7FF8, 16'h0202);
      total_cnt++;
      if (out_strobe !== 2'b01) $display("FAIL b2b_strobe2: got %b expected 01", out_strobe);
      else pass_cnt++;
      total_cnt++;
      if (out_data[15:0] !== 16'h0202) $display("FAIL b2b_ch0: got %h expected 0202", out_data[15:0]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_strobe !== 2'b00) $display("FAIL b2b_strobe_end: got %b expected 00", out_strobe);
      else pass_cnt++;
   endtask

   task automatic test_status_w1c;
      in_data  = {16'h2222, 16'h1111};
      in_valid = 2'b11;
      tick();
      in_valid = 2'b00;
      wait_capture();
      bus_rd(16'h7FFF);
      total_cnt++;
      if (bus.data_out !== 16'h0003) $display("FAIL w1c_pre: got %h expected 0003", bus.data_out);
      else pass_cnt++;
`ifdef IO_SYNC_EN
      bus_wr(16'h7FFF, 16'h0003);
      bus_rd(16'h7FFF);
      total_cnt++;
      if (bus.data_out !== 16'h0000) $display("FAIL w1c_clear: got %h expected 0000", bus.data_out);
      else pass_cnt++;
      in_data  = {16'h2222, 16'h3333};
      in_valid = 2'b01;
      tick();
      in_valid = 2'b00;
      wait_capture();
`else
      in_data  = {16'h2222, 16'h3333};
      in_valid = 2'b01;
      bus_wr(16'h7FFF, 16'h0003);
      in_valid = 2'b00;
`endif
      bus_rd(16'h7FFF);
      total_cnt++;
      if (bus.data_out !== 16'h0001) $display("FAIL w1c_setwins: got %h expected 0001", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h7FF0);
      total_cnt++;
      if (bus.data_out !== 16'h3333) $display("FAIL w1c_ch0: got %h expected 3333", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h7FFF);
      total_cnt++;
      if (bus.data_out !== 16'h0000) $display("FAIL w1c_final: got %h expected 0000", bus.data_out);
      else pass_cnt++;
   endtask

   task automatic test_unused;
      bus_wr(16'h7FF5, 16'h9999);
      total_cnt++;
      if (out_data !== 32'h00FF_0202) $display("FAIL unused_wr_out: got %h expected 00ff0202", out_data);
      else pass_cnt++;
      bus_rd(16'h7FF5);
      total_cnt++;
      if (bus.data_out !== 16'h0000) $display("FAIL unused_rd: got %h expected 0000", bus.data_out);
      else pass_cnt++;
      bus_wr(16'h7FF0, 16'h4444);
      bus_rd(16'h7FF0);
      total_cnt++;
      if (bus.data_out !== 16'h3333) $display("FAIL in_wr_ignored: got %h expected 3333", bus.data_out);
      else pass_cnt++;
   endtask

   task automatic test_reset_during_write;
      rst_n       = 1'b0;
      bus.address = 16'h7FF8;
      bus.data_in = 16'hFFFF;
      bus.wea     = 1'b1;
      tick();
      total_cnt++;
      if (out_data !== 32'h0) $display("FAIL rstwr_out_data: got %h expected 00000000", out_data);
      else pass_cnt++;
      total_cnt++;
      if (out_strobe !== 2'b00) $display("FAIL rstwr_strobe: got %b expected 00", out_strobe);
      else pass_cnt++;
      total_cnt++;
      if (bus.data_out !== 16'h0000) $display("FAIL rstwr_data_out: got %h expected 0000", bus.data_out);
      else pass_cnt++;
      bus.address = 16'h0005;
      tick();
      bus.wea     = 1'b0;
      rst_n       = 1'b1;
      bus_rd(16'h0005);
      total_cnt++;
      if (bus.data_out !== 16'h7777) $display("FAIL rst_ram_block: got %h expected 7777", bus.data_out);
      else pass_cnt++;
   endtask

`ifdef IO_SYNC_EN
   task automatic test_sync_capture;
      bus.address = 16'h7FFF;
      bus.wea     = 1'b0;
      in_data     = {16'h0000, 16'hCAFE};
      in_valid    = 2'b01;
      for (int k = 0; k < 3; k++) begin
         tick();
         total_cnt++;
         if (bus.data_out !== 16'h0000) $display("FAIL sync_early_%0d: got %h expected 0000", k, bus.data_out);
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (bus.data_out !== 16'h0001) $display("FAIL sync_capture: got %h expected 0001", bus.data_out);
      else pass_cnt++;
      bus_rd(16'h7FF0);
      total_cnt++;
      if (bus.data_out !== 16'hCAFE) $display("FAIL sync_ch0: got %h expected cafe", bus.data_out);
      else pass_cnt++;
      in_data = {16'h0000, 16'h1234};
      repeat (3) tick();
      bus_rd(16'h7FFF);
      total_cnt++;
      if (bus.data_out !== 16'h0000) $display("FAIL sync_once: got %h expected 0000", bus.data_out);
      else pass_cnt++;
      in_valid = 2'b00;
   endtask
`endif

   initial begin
      pass_cnt    = 0;
      total_cnt   = 0;
      rst_n       = 1'b0;
      bus.address = 16'h0000;
      bus.data_in = 16'h0000;
      bus.wea     = 1'b0;
      in_data     = 32'h0;
      in_valid    = 2'b00;

      test_reset();
      test_ram();
      test_input_capture();
`ifndef IO_SYNC_EN
      test_read_collision();
`endif
      test_output();
      test_status_w1c();
      test_unused();
      test_reset_during_write();
`ifdef IO_SYNC_EN
      test_sync_capture();
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/io_mem_ctrl.md
Name: io_mem_ctrl

Overview:
- Parametrised memory-mapped IO wrapper for the stack processor data bus.
- Wraps a behavioural single-port RAM (1-cycle read latency).
- Decodes a 16-word IO window holding N_IN captured input channels, N_OUT registered output channels and a status word.
- Sits between the core's data-memory port and board peripherals (switches, LEDs, seven-segment).

Parameters:
- DATA_W, 16, data bus and channel width.
- ADDR_W, 16, processor address width.
- MEM_AW, 10, RAM address bits; depth = 2**MEM_AW.
- N_IN, 2, input channels, 1..8.
- N_OUT, 2, output channels, 1..7.
- IO_BASE, 16'h7FF0, IO window base; must be 16-word aligned.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- address  in  ADDR_W  word address from core.
- data_in  in  DATA_W  write data from core.
- wea  in  1  write enable.
- data_out  out  DATA_W  read data, valid 1 cycle after address.
- in_data  in  N_IN*DATA_W  peripheral input words; channel i = bits [i*DATA_W +: DATA_W].
- in_valid  in  N_IN  per-channel capture strobe.
- out_data  out  N_OUT*DATA_W  registered output words, same packing as in_data.
- out_strobe  out  N_OUT  1-cycle pulse after each write to a channel.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Window decode: io_hit = (address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]); off = address[3:0].
- Offsets 0..N_IN-1: input channel reads. Offsets 8..8+N_OUT-1: output channels (read/write). Offset 15: STATUS. All other offsets read 0; writes to them are ignored.
- RAM writes: when wea && !io_hit, RAM[address[MEM_AW-1:0]] <= data_in. io_hit writes never reach RAM. Upper address bits above MEM_AW alias.
- Read path: at each edge, mem_q <= RAM[addr] (read-before-write on the same address), io_q <= IO mux, sel_q <= io_hit. data_out = sel_q ? io_q : mem_q. Latency 1 for both paths.
- Input capture: in_valid[i] high at an edge -> in_reg[i] <= in_data slice and in_new[i] <= 1.
- Reading offset i with wea=0 clears in_new[i]. If a read and in_valid[i] coincide, set wins: in_new[i] stays 1, the read returns the old in_reg[i], and in_reg[i] takes the new value.
- STATUS read = {0, in_new[N_IN-1:0]}; reading it does not clear anything.
- STATUS write is write-1-to-clear on in_new bits, except bits where in_valid is set in the same cycle (set wins).
- Writes to input offsets are ignored.
- Output channels: write to offset 8+j -> out_reg[j] <= data_in at that edge, and out_strobe[j] = 1 for exactly the next cycle. Back-to-back writes give a continuous strobe.
- Out_data is register-driven only; there is no combinational path from data_in.
- Reset (rst_n=0 at an edge): in_reg, in_new, out_reg, out_strobe, mem_q, io_q and sel_q all go to 0, so data_out = 0 the cycle after reset. RAM contents are not reset; RAM writes are blocked while rst_n=0.
- Reset overrides any simultaneous write or capture.

Optional Feature:
- Macro: IO_SYNC_EN.
- Defined: each in_valid bit passes a 2-flop synchroniser plus rising-edge detect. Capture occurs on the edge where the synchronised rising edge is seen, 3 edges after in_valid rises. in_data must be held stable from in_valid rise through capture. A held-high in_valid captures once.
- Undefined: in_valid is sampled directly; every high cycle captures (level strobe, 1 edge latency).
- Synchroniser flops reset to 0.

Test Plan:
- Reset, then write 0x1234 to 0x0005, read 0x0005 -> data_out = 0x1234 one cycle later; write to 0x7FF8 (IO_BASE+8) leaves RAM[0x3F8] unchanged.
- in_data ch0 = 0xBEEF, in_valid[0] one cycle (IO_SYNC_EN off) -> STATUS reads 0x0001; read 0x7FF0 -> 0xBEEF; next STATUS read -> 0x0000.
- Read 0x7FF1 in the same cycle in_valid[1] pulses with 0xAAAA (old 0x5555) -> returns 0x5555; in_new[1] stays 1; next read -> 0xAAAA.
- Write 0x00FF to 0x7FF9 -> out_data ch1 = 0x00FF and out_strobe = 2'b10 for one cycle; read 0x7FF9 -> 0x00FF; out_data ch0 unchanged.
- Write 0x0003 to 0x7FFF with in_new = 2'b11 and in_valid[0] high -> in_new = 2'b01. Reads/writes to 0x7FF5 -> 0, ignored.
- Drive rst_n=0 during a write to 0x7FF8 -> out_reg, out_strobe and data_out = 0. With IO_SYNC_EN, a held in_valid captures once, 3 edges after it rises.
